// File: rtl/stereo_pkg.sv
// Shared types and the RGB-to-luma helper for the side-by-side stereo input stage.
package stereo_pkg;

    localparam int SAMPLES    = 4;
    localparam int DATA_WIDTH = 24;
    localparam int LUMA_WIDTH = 8;

    typedef logic [LUMA_WIDTH-1:0] luma_t;
    typedef luma_t [SAMPLES-1:0]   beat4_luma_t;

    typedef enum logic [1:0] {
        WAIT_SOF,
        LEFT,
        RIGHT
    } sbs_state_t;

    // (R + 2G + B) / 4; the 10-bit sum cannot overflow for 8-bit channels.
    function automatic luma_t rgb2luma(input logic [DATA_WIDTH-1:0] rgb);
        logic [9:0] sum;
        sum = 10'(rgb[23:16]) + {1'b0, rgb[15:8], 1'b0} + 10'(rgb[7:0]);
        return sum[9:2];
    endfunction

endpackage

// File: rtl/sbs_line_buffer.sv
// Half-line luma store: synchronous write, asynchronous (LUTRAM-style) read.
module sbs_line_buffer #(
    parameter int DEPTH     = 185,
    parameter int DATA_BITS = 32,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stereo_sbs_split.sv
// Splits an SBS RGB stream into per-column {right, left} luma pairs.
// Define SBS_SWAP_EN when the first half of each input line is the right camera.
module stereo_sbs_split #(
    parameter int WIDTH      = 740,
    parameter int HEIGHT     = 497,
    parameter int SAMPLES    = 4,
    parameter int DATA_WIDTH = 24
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [SAMPLES*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tlast,
    output logic [SAMPLES*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          sync_err
);

    import stereo_pkg::*;

    localparam int BEATS  = WIDTH / SAMPLES;
    localparam int COL_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BUF_W  = SAMPLES * LUMA_WIDTH;

    sbs_state_t          state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q;
    logic                ready_en;
    logic                sof_pending;

    logic                accept;
    logic                last_col;
    logic                wr_en;
    logic [COL_W-1:0]    wr_addr;
    logic                emit;
    logic                err;

    logic [BUF_W-1:0]              in_luma;
    logic [BUF_W-1:0]              buf_luma;
    logic [SAMPLES*DATA_WIDTH-1:0] out_pix;

    sbs_line_buffer #(
        .DEPTH     (BEATS),
        .DATA_BITS (BUF_W)
    ) u_line_buffer (
        .clk   (aclk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (in_luma),
        .raddr (col_q),
        .rdata (buf_luma)
    );

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        in_luma = '0;
        out_pix = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            in_luma[k*LUMA_WIDTH +: LUMA_WIDTH] = rgb2luma(s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]);
`ifdef SBS_SWAP_EN
            out_pix[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'({8'h00,
                buf_luma[k*LUMA_WIDTH +: LUMA_WIDTH], in_luma[k*LUMA_WIDTH +: LUMA_WIDTH]});
`else
            out_pix[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'({8'h00,
                in_luma[k*LUMA_WIDTH +: LUMA_WIDTH], buf_luma[k*LUMA_WIDTH +: LUMA_WIDTH]});
`endif
        end
    end

    assign last_col = (col_q == COL_W'(BEATS - 1));
    assign accept   = s_axis_tvalid && s_axis_tready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= WAIT_SOF;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // A tuser beat always restarts as LEFT column 0, whatever else it carries.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        if (accept) begin
            if (s_axis_tuser) begin
                state_d = LEFT;
                col_d   = COL_W'(1);
            end else begin
                unique case (state_q)
                    LEFT: begin
                        if (s_axis_tlast) begin
                            col_d = '0;
                        end else if (last_col) begin
                            state_d = RIGHT;
                            col_d   = '0;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                    RIGHT: begin
                        if (s_axis_tlast || last_col) begin
                            state_d = LEFT;
                            col_d   = '0;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        s_axis_tready = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = col_q;
        emit          = 1'b0;
        err           = 1'b0;

        unique case (state_q)
            RIGHT:   s_axis_tready = !m_axis_tvalid || m_axis_tready;
            default: s_axis_tready = ready_en;
        endcase

        if (accept) begin
            wr_en   = s_axis_tuser || (state_q == LEFT);
            wr_addr = s_axis_tuser ? '0 : col_q;
            emit    = !s_axis_tuser && (state_q == RIGHT) && (!s_axis_tlast || last_col);

            if (s_axis_tuser && !((state_q == WAIT_SOF) || ((state_q == LEFT) && (col_q == '0))))
                err = 1'b1;
            if (s_axis_tlast && !((state_q == RIGHT) && last_col) &&
                (s_axis_tuser || (state_q != WAIT_SOF)))
                err = 1'b1;
            if (!s_axis_tuser && (state_q == RIGHT) && last_col && !s_axis_tlast)
                err = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ready_en      <= 1'b0;
            line_q        <= '0;
            sof_pending   <= 1'b0;
            sync_err      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            sync_err <= err;

            if (accept && s_axis_tuser) begin
                line_q      <= '0;
                sof_pending <= 1'b1;
            end else if (emit) begin
                sof_pending <= 1'b0;
                if (last_col)
                    line_q <= (line_q == LINE_W'(HEIGHT - 1)) ? '0 : line_q + 1'b1;
            end

            // Missing tlast on the final column still closes the output line.
            if (emit) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= out_pix;
                m_axis_tuser  <= sof_pending;
                m_axis_tlast  <= last_col;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stereo_sbs_split.sv
// Self-checking bench for stereo_sbs_split: random pixels, directed resync cases, scoreboard.
module tb_stereo_sbs_split;

    localparam int WIDTH      = 32;
    localparam int HEIGHT     = 4;
    localparam int SAMPLES    = 4;
    localparam int DATA_WIDTH = 24;
    localparam int BEATS      = WIDTH / SAMPLES;
    localparam int BW         = SAMPLES * DATA_WIDTH;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [BW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          sync_err;

    stereo_sbs_split #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .SAMPLES    (SAMPLES),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .sync_err      (sync_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          user;
        logic          last;
    } out_beat_t;

    out_beat_t exp_q[$];
    out_beat_t got;
    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    int seen_err = 0;
    int tready_mode = 1;   // 0 random, 1 always ready, 2 never ready

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference luma straight from the arithmetic rule.
    function automatic logic [7:0] luma(input logic [23:0] p);
        int s;
        s = int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0]);
        return 8'(s / 4);
    endfunction

    function automatic logic [BW-1:0] pack_out(input logic [BW-1:0] first, input logic [BW-1:0] second);
        logic [BW-1:0] r;
        logic [7:0] l1, l2;
        r = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            l1 = luma(first[k*24 +: 24]);
            l2 = luma(second[k*24 +: 24]);
`ifdef SBS_SWAP_EN
            r[k*24 +: 24] = {8'h00, l1, l2};
`else
            r[k*24 +: 24] = {8'h00, l2, l1};
`endif
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] d;
        for (int k = 0; k < SAMPLES; k++) d[k*24 +: 24] = 24'($urandom);
        return d;
    endfunction

    always @(posedge aclk) begin
        #1;
        case (tready_mode)
            0:       m_axis_tready = 1'($urandom_range(0, 1));
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Scoreboard and hold-while-stalled monitor, sampled on the falling edge.
    logic [BW-1:0] prev_data;
    logic          prev_user, prev_last;
    logic          prev_stall = 1'b0;

    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (sync_err) seen_err++;
            if (prev_stall) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, prev_data);
                check("stall_user", m_axis_tuser, prev_user);
                check("stall_last", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("out_data", m_axis_tdata, got.data);
                    check("out_user", m_axis_tuser, got.user);
                    check("out_last", m_axis_tlast, got.last);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_user  = m_axis_tuser;
            prev_last  = m_axis_tlast;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic send_beat(input logic [BW-1:0] d, input logic u, input logic l, input bit left_half);
        int waited;
        waited = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        if (left_half) check("left_ready", s_axis_tready, 1);
        while (!s_axis_tready && waited < 200) begin
            @(negedge aclk);
            waited++;
        end
        check("accept_in_time", waited < 200, 1);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_line(input bit sof, input int early_col, input bit drop_last);
        logic [BW-1:0] first [BEATS];
        logic [BW-1:0] second;
        for (int j = 0; j < BEATS; j++) begin
            first[j] = rand_beat();
            send_beat(first[j], sof && (j == 0), 1'b0, 1'b1);
        end
        for (int j = 0; j < BEATS; j++) begin
            second = rand_beat();
            if (j == early_col) begin
                exp_err++;
                send_beat(second, 1'b0, 1'b1, 1'b0);
                break;
            end
            exp_q.push_back('{data: pack_out(first[j], second), user: sof && (j == 0), last: j == BEATS - 1});
            send_beat(second, 1'b0, (j == BEATS - 1) && !drop_last, 1'b0);
        end
        if (drop_last) exp_err++;
    endtask

    task automatic send_frame();
        for (int i = 0; i < HEIGHT; i++) send_line(i == 0, -1, 1'b0);
    endtask

    task automatic drain(input string tag);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 1000) begin
            @(posedge aclk);
            waited++;
        end
        repeat (3) @(posedge aclk);
        #1;
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_sync_err_count"}, seen_err, exp_err);
    endtask

    initial begin
        logic [BW-1:0] luma_left;
        logic [BW-1:0] luma_exp;

        // Reset values
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tuser", m_axis_tuser, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_sync_err", sync_err, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("ready_after_reset", s_axis_tready, 1);
        @(posedge aclk);
        #1;

        // Pre-SOF beats are dropped silently
        for (int i = 0; i < 5; i++) send_beat(rand_beat(), 1'b0, i == 4, 1'b0);

        // Clean frame, then a frame under random backpressure
        send_frame();
        drain("frame_clean");
        tready_mode = 0;
        send_frame();
        drain("frame_backpressure");

        // Early tlast on a RIGHT beat, next line must realign
        send_line(1'b1, -1, 1'b0);
        send_line(1'b0, 3, 1'b0);
        send_line(1'b0, -1, 1'b0);
        drain("early_tlast");

        // tuser in the middle of a LEFT half starts a new frame there
        for (int i = 0; i < 5; i++) send_beat(rand_beat(), 1'b0, 1'b0, 1'b1);
        exp_err++;
        send_line(1'b1, -1, 1'b0);
        send_line(1'b0, -1, 1'b0);
        drain("midline_tuser");

        // Missing tlast on the final RIGHT beat still closes the line
        send_line(1'b0, -1, 1'b1);
        send_line(1'b0, -1, 1'b0);
        drain("missing_tlast");

        // Luma corner values: white, pure red, (1,1,1), black against a white right half
        luma_left = {24'h000000, 24'h010101, 24'hFF0000, 24'hFFFFFF};
`ifdef SBS_SWAP_EN
        luma_exp  = {24'h0000FF, 24'h0001FF, 24'h003FFF, 24'h00FFFF};
`else
        luma_exp  = {24'h00FF00, 24'h00FF01, 24'h00FF3F, 24'h00FFFF};
`endif
        tready_mode = 1;
        for (int j = 0; j < BEATS; j++) send_beat(luma_left, j == 0, 1'b0, 1'b1);
        for (int j = 0; j < BEATS; j++) begin
            exp_q.push_back('{data: luma_exp, user: j == 0, last: j == BEATS - 1});
            send_beat({BW{1'b1}}, 1'b0, j == BEATS - 1, 1'b0);
        end
        drain("luma_values");

        // Reset while an output beat is stalled in RIGHT
        tready_mode = 2;
        @(posedge aclk);
        #1;
        for (int j = 0; j < BEATS; j++) send_beat(rand_beat(), j == 0, 1'b0, 1'b1);
        send_beat(rand_beat(), 1'b0, 1'b0, 1'b0);
        s_axis_tdata  = rand_beat();
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        check("stalled_m_tvalid", m_axis_tvalid, 1);
        check("stalled_s_tready", s_axis_tready, 0);
        @(posedge aclk);
        #1 areset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("midrst_m_tvalid", m_axis_tvalid, 0);
        check("midrst_s_tready", s_axis_tready, 0);
        check("midrst_m_tdata", m_axis_tdata, 0);
        check("midrst_m_tlast", m_axis_tlast, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        tready_mode = 1;
        repeat (2) @(posedge aclk);
        #1;
        for (int i = 0; i < 2 * BEATS; i++) send_beat(rand_beat(), 1'b0, i == BEATS, 1'b0);
        send_frame();
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stereo_sbs_split.md
# stereo_sbs_split

Input stage placed directly upstream of `Stereovision_v1_0`. It accepts a side-by-side (SBS) stereo video stream from the HDMI/AXI4-Stream input at 4 RGB pixels per clock, where each input line is the left-camera line followed by the right-camera line. It converts each pixel to 8-bit luma, buffers the left half of the line, and emits one output line per input line. Each output pixel carries the left and right luma samples at the same column, which is the format the disparity core consumes.

## Interface
- `WIDTH`, default 740: pixels per camera line (output line width). Must be a multiple of `SAMPLES`.
- `HEIGHT`, default 497: lines per frame. Used only for the end-of-frame line count.
- `SAMPLES`, default 4: pixels per beat.
- `DATA_WIDTH`, default 24: bits per pixel, RGB 8:8:8 with R in [23:16], G in [15:8], B in [7:0].
- `aclk`  in  1: single clock for all logic.
- `areset`  in  1: reset, synchronous and active-high.
- `s_axis_tdata`  in  `SAMPLES*DATA_WIDTH`: input SBS pixels. Pixel k is at bits [24k+23:24k]; k=0 is the leftmost pixel.
- `s_axis_tvalid`  in  1: input beat valid.
- `s_axis_tready`  out  1: input beat accepted.
- `s_axis_tuser`  in  1: start of frame, asserted on the first beat of a frame.
- `s_axis_tlast`  in  1: end of line, asserted on the last beat of each 2*`WIDTH`-pixel input line.
- `m_axis_tdata`  out  `SAMPLES*DATA_WIDTH`: output pixel k = {8'h00, right_luma, left_luma}.
- `m_axis_tvalid`  out  1: output beat valid.
- `m_axis_tready`  in  1: downstream ready.
- `m_axis_tuser`  out  1: start of frame, on the first output beat of a frame.
- `m_axis_tlast`  out  1: end of line, on output beat `WIDTH/SAMPLES-1`.
- `sync_err`  out  1: one-cycle pulse on any resynchronisation event.

## Operation
- Luma per pixel: (R + 2*G + B) >> 2. The sum is 10 bits unsigned; the result is truncated to 8 bits. The maximum input 255/255/255 gives 255, so no overflow occurs.
- Constant BEATS = `WIDTH/SAMPLES` (185 at defaults).
- Line buffer: BEATS entries x 32 bits (4 luma values per entry). Write is synchronous; read is asynchronous (LUTRAM).
- FSM states:
  - WAIT_SOF: `s_axis_tready`=1. Beats are discarded. A beat with tuser set is processed as beat 0 of LEFT, and the FSM goes to LEFT.
  - LEFT: `s_axis_tready`=1. Luma is written to buffer[col]. col increments each beat; at col=BEATS-1 the FSM goes to RIGHT with col cleared.
  - RIGHT: `s_axis_tready` = !`m_axis_tvalid` || `m_axis_tready`. An accepted beat loads the output register: left luma from buffer[col], right luma from the input. The output register's tlast is set when col=BEATS-1. At col=BEATS-1 the FSM goes to LEFT, col is cleared and line is incremented.
- Frame tracking:
  - The output tuser is set on the first RIGHT beat after a tuser-marked LEFT beat.
  - line wraps to 0 at `HEIGHT`-1.
- Resynchronisation (`sync_err` pulses, other effects listed per case):
  - tuser on any beat other than LEFT col 0: that beat becomes LEFT col 0 of a new frame, and line=0.
  - tlast on a beat other than RIGHT col BEATS-1: the beat is consumed, its output (if RIGHT) is not emitted, and the FSM goes to LEFT with col=0.
  - No tlast on RIGHT col BEATS-1: the beat is still emitted with output tlast=1.
  - If tuser and an early tlast occur on the same beat, tuser wins. The beat is written as LEFT col 0 and the FSM goes to LEFT with col=1.

## Timing
- Reset values: `s_axis_tready`=0 during reset and 1 from the first cycle after. `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0, `m_axis_tlast`=0, `sync_err`=0. FSM=WAIT_SOF, col=0, line=0. Buffer contents are don't-care.
- Reset asserted mid-line drops the output register contents, even if unaccepted.
- Latency: a RIGHT beat accepted in cycle n gives `m_axis_tvalid`=1 in cycle n+1.
- The output register holds tdata/tuser/tlast stable while tvalid=1 and tready=0.
- Throughput: 1 beat/cycle in both phases when `m_axis_tready`=1. There are no bubbles at the LEFT/RIGHT or line boundaries.
- During LEFT the input is never stalled. A pending output beat drains during LEFT independently.

## Configuration
- `SBS_SWAP_EN` defined: the first half of each input line is the right camera. The buffer holds the right luma, and the output packs the current input as left luma.
- `SBS_SWAP_EN` undefined: the first half is the left camera, as described in Operation.
- The output bit layout is identical in both cases.

## Structure
- Package `stereo_pkg`: `SAMPLES`, the `DATA_WIDTH` localparams, `luma_t` (8-bit), `beat4_luma_t` (4 x `luma_t`), the FSM state enum (WAIT_SOF, LEFT, RIGHT), and the `rgb2luma` function.
- Sub-module `sbs_line_buffer`: parameterised depth/width RAM with a synchronous write port and an asynchronous read port.
- FSM, counters and output register are in `stereo_sbs_split`.

## Test plan
- Normal frame: 2 frames of 740x497 SBS with left pixel RGB=(col%256) gray and right = left+1. Expect output pixel k = {00, (col+1)%256, col%256}, 185 beats/line, tlast on beat 184, tuser only on line 0 beat 0, `sync_err` never 1.
- Random backpressure: `m_axis_tready` 50% random. Expect an identical output sequence, no data change while stalled, and `s_axis_tready` always 1 in LEFT.
- Early tlast: tlast on RIGHT col 100. Expect `sync_err` pulse, no output for that beat, and the next line aligned.
- Mid-line tuser: tuser on LEFT col 50. Expect `sync_err`, and the next output beat after 185 LEFT beats has tuser=1.
- Reset mid-RIGHT with `m_axis_tvalid`=1, `m_axis_tready`=0. Expect `m_axis_tvalid`=0 the next cycle, and input ignored until tuser.
- Luma arithmetic: RGB=(255,255,255) -> 255; (255,0,0) -> 63; (1,1,1) -> 1.
